full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have one parameter: REG_OUT, default 1, 1 = registered outputs sum_q/cout_q/valid_q are active, 0 = they are tied to 0.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port a, input, 1 bit, addend bit A.
REQ-005 The block SHALL have port b, input, 1 bit, addend bit B.
REQ-006 The block SHALL have port cin, input, 1 bit, carry-in.
REQ-007 The block SHALL have port in_valid, input, 1 bit, which qualifies a/b/cin for the registered path.
REQ-008 The block SHALL have port sum, output, 1 bit, the combinational sum.
REQ-009 The block SHALL have port cout, output, 1 bit, the combinational carry-out.
REQ-010 The block SHALL have port sum_q, output, 1 bit, the registered sum.
REQ-011 The block SHALL have port cout_q, output, 1 bit, the registered carry-out.
REQ-012 The block SHALL have port valid_q, output, 1 bit, which flags that sum_q/cout_q hold a fresh result.

Function
REQ-013 sum SHALL equal a XOR b XOR cin, combinationally, with zero cycle latency.
REQ-014 cout SHALL equal (a AND b) OR (cin AND (a XOR b)), combinationally.
REQ-015 {cout,sum} SHALL equal the 2-bit arithmetic sum a+b+cin for all 8 input combinations; no overflow is possible.
REQ-016 sum and cout SHALL be independent of clk, rst and in_valid.
REQ-017 With REG_OUT=1, on a rising clk edge with in_valid=1, sum_q/cout_q SHALL capture the current sum/cout, and valid_q SHALL become 1 (one-cycle latency).
REQ-018 With REG_OUT=1, on a rising clk edge with in_valid=0, sum_q/cout_q SHALL hold their values and valid_q SHALL become 0.
REQ-019 Back-to-back in_valid=1 cycles SHALL each produce a result one cycle later, with no bubbles (full throughput).
REQ-020 With REG_OUT=0, sum_q, cout_q and valid_q SHALL be constant 0 and no flops SHALL be inferred.
REQ-021 Inputs at X/Z are outside the contract; no special handling is required.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for clk, drive sum_q=0, cout_q=0 and valid_q=0.
REQ-023 While rst=1, the registered outputs SHALL stay 0 regardless of in_valid or clk.
REQ-024 The first capture after reset SHALL occur on the first rising clk edge after rst deasserts with in_valid=1.
REQ-025 rst SHALL NOT affect the combinational sum/cout.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; valid_q SHALL return to 0.

Structure
REQ-027 The combinational path SHALL be built from two instances of a sub-module half_adder (ports a, b, sum, carry) plus one OR gate for cout.
REQ-028 No shared package is required; REG_OUT is the only constant and is local to the module.
REQ-029 The registered stage SHALL be a single always block sensitive to posedge clk and posedge rst.

Verification
REQ-030 The bench SHALL cover an exhaustive sweep: apply all 8 {a,b,cin} values from 000 to 111, with 10 time units each -> {cout,sum} = 00,01,01,10,01,10,10,11 respectively.
REQ-031 The bench SHALL cover the registered path: with in_valid=1 and a=1,b=1,cin=1 at edge N -> sum_q=1, cout_q=1, valid_q=1 after edge N.
REQ-032 The bench SHALL cover hold behaviour: with in_valid=0 and inputs changed to 000 -> sum_q/cout_q keep 1/1 and valid_q=0 on the next edge.
REQ-033 The bench SHALL cover asynchronous reset: assert rst between edges while valid_q=1 -> sum_q=cout_q=valid_q=0 at once, while sum/cout still track the inputs.
REQ-034 The bench SHALL cover streaming: 8 consecutive in_valid=1 cycles with the sweep inputs -> registered outputs match REQ-030 values, each delayed by exactly one cycle.
REQ-035 The bench SHALL cover REG_OUT=0: any stimulus -> sum_q=cout_q=valid_q=0 and the combinational outputs are unchanged.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared types for the full adder: the {cout,sum} result pair carried by the registered stage.
package full_adder_pkg;

    localparam int unsigned RESULT_W = 2;

    typedef struct packed {
        logic cout;
        logic sum;
    } fa_result_t;

    // Packs carry and sum into a result word, carry in the MSB.
    function automatic fa_result_t fa_pack(input logic carry, input logic s);
        fa_result_t r;
        r.cout = carry;
        r.sum  = s;
        return r;
    endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder: sum = a ^ b, carry = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders, with an optional valid-qualified output register.
module full_adder
    import full_adder_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic in_valid,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q,
    output logic valid_q
);

    logic       ha0_sum;
    logic       ha0_carry;
    logic       ha1_carry;
    fa_result_t result;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (cin),
        .sum   (sum),
        .carry (ha1_carry)
    );

    // At most one of the two half-adder carries can be set, so OR completes the carry.
    assign cout   = ha0_carry | ha1_carry;
    assign result = fa_pack(cout, sum);

    generate
        if (REG_OUT) begin : g_reg
            fa_result_t result_q;
            logic       valid_r;

            // Result holds when in_valid is low; valid drops so stale data is not re-flagged.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    result_q <= '0;
                    valid_r  <= 1'b0;
                end else begin
                    valid_r <= in_valid;
                    if (in_valid) begin
                        result_q <= result;
                    end
                end
            end

            assign sum_q   = result_q.sum;
            assign cout_q  = result_q.cout;
            assign valid_q = valid_r;
        end else begin : g_noreg
            assign sum_q   = 1'b0;
            assign cout_q  = 1'b0;
            assign valid_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational sweep, registered path via scoreboard, reset, REG_OUT=0.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;
    logic a, b, cin, in_valid;

    logic sum1, cout1, sum_q1, cout_q1, valid_q1;
    logic sum0, cout0, sum_q0, cout_q0, valid_q0;

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [1:0] sb[$];
    logic [1:0] last_q;
    logic [1:0] sweep_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    always #5 clk = ~clk;

    full_adder #(.REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .valid_q(valid_q1)
    );

    full_adder #(.REG_OUT(1'b0)) dut_noreg (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum0), .cout(cout0), .sum_q(sum_q0), .cout_q(cout_q0), .valid_q(valid_q0)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [1:0] model(input logic [2:0] v);
        return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    endfunction

    // Combinational outputs of both instances, plus the tied-off outputs of REG_OUT=0.
    task automatic chk_comb(input string tag);
        logic [1:0] exp;
        exp = model({a, b, cin});
        chk({tag, "_comb"},   {cout1, sum1}, exp);
        chk({tag, "_comb0"},  {cout0, sum0}, exp);
        chk({tag, "_noreg"},  {1'b0, sum_q0 | cout_q0 | valid_q0}, 2'b00);
    endtask

    task automatic drive(input logic [2:0] v, input logic vld);
        @(negedge clk);
        {a, b, cin} = v;
        in_valid    = vld;
        if (vld) sb.push_back(model(v));
    endtask

    task automatic tick(input string tag);
        logic [1:0] exp;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp    = sb.pop_front();
            last_q = exp;
            chk({tag, "_valid"}, {1'b0, valid_q1}, 2'b01);
            chk({tag, "_q"},     {cout_q1, sum_q1}, exp);
        end else begin
            chk({tag, "_valid"}, {1'b0, valid_q1}, 2'b00);
            chk({tag, "_hold"},  {cout_q1, sum_q1}, last_q);
        end
        chk_comb(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; in_valid = 1'b1;
        last_q = 2'b00;
        #2;
        chk("reset_q",     {cout_q1, sum_q1}, 2'b00);
        chk("reset_valid", {1'b0, valid_q1},  2'b00);
        @(posedge clk); #1;
        chk("reset_hold_valid", {1'b0, valid_q1}, 2'b00);
        chk_comb("reset");

        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Exhaustive sweep, 10 time units per value
        for (int v = 0; v < 8; v++) begin
            {a, b, cin} = 3'(v);
            #1;
            chk($sformatf("sweep%0d", v), {cout1, sum1}, sweep_exp[v]);
            chk_comb($sformatf("sweep%0d", v));
            #9;
        end

        // First capture after reset, then hold
        drive(3'b111, 1'b1);
        tick("cap111");
        drive(3'b000, 1'b0);
        tick("hold000");

        // Mid-stream async reset: one result visible, one in flight
        drive(3'b111, 1'b1);
        tick("pre_rst");
        drive(3'b101, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q",     {cout_q1, sum_q1}, 2'b00);
        chk("async_rst_valid", {1'b0, valid_q1},  2'b00);
        chk_comb("async_rst");
        {a, b, cin} = 3'b010;
        #1;
        chk("rst_comb_track", {cout1, sum1}, 2'b01);
        sb.delete();
        last_q = 2'b00;
        @(posedge clk); #1;
        chk("rst_held_q",     {cout_q1, sum_q1}, 2'b00);
        chk("rst_held_valid", {1'b0, valid_q1},  2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Streaming sweep, back to back
        for (int v = 0; v < 8; v++) begin
            drive(3'(v), 1'b1);
            if (v > 0) ;
            tick($sformatf("stream%0d", v));
            chk($sformatf("stream_tab%0d", v), {cout_q1, sum_q1}, sweep_exp[v]);
        end
        drive(3'b110, 1'b0);
        tick("stream_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
